// File: rtl/scan_position_stepper.sv
// Scan position generator: steps a saturating position left/right once every
// TICK_DIV enabled clocks, with a matching one-hot LED vector and a step strobe.
module scan_position_stepper #(
  parameter int unsigned POS_W    = 3,
  parameter int          TICK_DIV = 4
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  input  logic                  en_i,
  input  logic                  dir_i,
  input  logic                  load_i,
  input  logic [POS_W-1:0]      load_val_i,
  output logic [POS_W-1:0]      pos_o,
  output logic [(2**POS_W)-1:0] led_o,
  output logic                  step_o,
  output logic                  at_edge_o
);

  localparam int unsigned LedW = 2 ** POS_W;
  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [POS_W-1:0] PosMax  = {POS_W{1'b1}};
  localparam logic [CntW-1:0]  CntLast = CntW'(TICK_DIV - 1);

  if (TICK_DIV < 1) begin : g_bad_tick_div
    $error("scan_position_stepper: TICK_DIV must be >= 1");
  end

  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [LedW-1:0]  led_q, led_d;
  logic             step_q, step_d;
  logic             opportunity;

  assign opportunity = en_i && (cnt_q == CntLast);

  // Next-state: load beats the step opportunity; ends saturate without a strobe.
  always_comb begin
    cnt_d  = cnt_q;
    pos_d  = pos_q;
    step_d = 1'b0;
    if (load_i) begin
      pos_d = load_val_i;
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = opportunity ? '0 : cnt_q + CntW'(1);
      if (opportunity) begin
        if (dir_i && (pos_q != PosMax)) begin
          pos_d  = pos_q + POS_W'(1);
          step_d = 1'b1;
        end else if (!dir_i && (pos_q != '0)) begin
          pos_d  = pos_q - POS_W'(1);
          step_d = 1'b1;
        end
      end
    end
    // Derived from pos_d so led and pos always change on the same edge.
    led_d = LedW'(1) << pos_d;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (arst_i) begin
      cnt_q  <= '0;
      pos_q  <= '0;
      led_q  <= LedW'(1);
      step_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pos_q  <= pos_d;
      led_q  <= led_d;
      step_q <= step_d;
    end
  end

  assign pos_o     = pos_q;
  assign led_o     = led_q;
  assign step_o    = step_q;
  assign at_edge_o = (pos_q == '0) || (pos_q == PosMax);

endmodule

// File: tb/tb_scan_position_stepper.sv
// Bench for scan_position_stepper: directed stimulus pushes expected step events
// into scoreboards; monitors pop and compare whenever a step strobe appears.
module tb_scan_position_stepper;

  logic       clk = 1'b0;
  logic       arst, en, dir, load;
  logic [2:0] load_val;
  logic [2:0] pos;
  logic [7:0] led;
  logic       step, at_edge;

  // Second instance, TICK_DIV=2, closed loop with a bench direction FSM.
  logic       en2, dir2;
  logic [2:0] pos2;
  logic [7:0] led2;
  logic       step2, at_edge2;

  int cyc = 0;
  int n_pass = 0;
  int n_total = 0;

  int exp_cyc_q[$];
  int exp_pos_q[$];
  int exp2_pos_q[$];

  always #5 clk = ~clk;

  scan_position_stepper #(.POS_W(3), .TICK_DIV(4)) dut (
    .clk_i(clk), .arst_i(arst), .en_i(en), .dir_i(dir), .load_i(load),
    .load_val_i(load_val), .pos_o(pos), .led_o(led), .step_o(step), .at_edge_o(at_edge)
  );

  scan_position_stepper #(.POS_W(3), .TICK_DIV(2)) dut2 (
    .clk_i(clk), .arst_i(arst), .en_i(en2), .dir_i(dir2), .load_i(1'b0),
    .load_val_i(3'd0), .pos_o(pos2), .led_o(led2), .step_o(step2), .at_edge_o(at_edge2)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in for two_state_fsm: flips dir one clock after pos reaches an end.
  always @(posedge clk) begin
    if (arst) dir2 <= 1'b1;
    else if (pos2 == 3'd7) dir2 <= 1'b0;
    else if (pos2 == 3'd0) dir2 <= 1'b1;
  end

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_step(input int at_cyc, input int p);
    exp_cyc_q.push_back(at_cyc);
    exp_pos_q.push_back(p);
  endtask

  // Monitor for the TICK_DIV=4 instance.
  always @(negedge clk) begin
    if (step === 1'b1) begin
      if (exp_pos_q.size() == 0) begin
        check("unexpected_step", 1, 0);
      end else begin
        int ec, ep;
        ec = exp_cyc_q.pop_front();
        ep = exp_pos_q.pop_front();
        check("step_cycle", cyc, ec);
        check("step_pos", int'(pos), ep);
        check("step_led", int'(led), 1 << ep);
      end
    end
  end

  // Monitor for the closed-loop instance.
  always @(negedge clk) begin
    if (step2 === 1'b1) begin
      if (exp2_pos_q.size() == 0) begin
        check("loop_unexpected_step", 1, 0);
      end else begin
        int ep;
        ep = exp2_pos_q.pop_front();
        check("loop_pos", int'(pos2), ep);
        check("loop_led", int'(led2), 1 << ep);
      end
    end
  end

  initial begin
    int t, p, d;
    arst = 1'b1; en = 1'b0; dir = 1'b1; load = 1'b0; load_val = 3'd0; en2 = 1'b0;
    run(1);
    arst = 1'b0;
    check("reset_pos", int'(pos), 0);
    check("reset_led", int'(led), 8'h01);
    check("reset_step", int'(step), 0);
    check("reset_at_edge", int'(at_edge), 1);

    // Stepping right from reset: one step every 4 enabled clocks up to 7.
    en = 1'b1; dir = 1'b1;
    t = cyc;
    for (int k = 1; k <= 7; k++) push_step(t + 4 * k, k);
    run(28);
    check("climb_pos", int'(pos), 7);

    // Three saturated opportunities at the right end.
    run(12);
    check("sat_pos", int'(pos), 7);
    check("sat_led", int'(led), 8'h80);
    check("sat_at_edge", int'(at_edge), 1);
    check("sat_step", int'(step), 0);

    // Reverse: next opportunity steps to 6.
    dir = 1'b0;
    push_step(cyc + 4, 6);
    run(4);

    // Load at cnt=2 restarts the prescaler.
    run(2);
    load = 1'b1; load_val = 3'd5;
    run(1);
    load = 1'b0;
    check("load_pos", int'(pos), 5);
    check("load_led", int'(led), 8'h20);
    check("load_step", int'(step), 0);
    push_step(cyc + 4, 4);
    run(4);
    check("mid_at_edge", int'(at_edge), 0);

    // Enable freeze at cnt=1, then 3 more clocks to the step.
    run(1);
    en = 1'b0;
    run(10);
    check("freeze_pos", int'(pos), 4);
    en = 1'b1;
    push_step(cyc + 3, 3);
    run(3);

    // Reset mid-count; the first step follows exactly 4 enabled clocks later.
    run(2);
    arst = 1'b1;
    run(1);
    arst = 1'b0;
    check("rst2_pos", int'(pos), 0);
    check("rst2_led", int'(led), 8'h01);
    check("rst2_step", int'(step), 0);
    dir = 1'b1;
    push_step(cyc + 4, 1);
    run(4);

    // Load on an opportunity edge wins over the step.
    run(3);
    load = 1'b1; load_val = 3'd0;
    run(1);
    load = 1'b0;
    check("load_prio_pos", int'(pos), 0);
    check("load_prio_step", int'(step), 0);

    // Saturate at the left end: two opportunities, no step.
    dir = 1'b0;
    run(8);
    check("sat0_pos", int'(pos), 0);
    check("sat0_led", int'(led), 8'h01);
    en = 1'b0;

    // Closed loop, TICK_DIV=2: clean bounce 1..7..0..
    p = 0; d = 1;
    for (int k = 0; k < 20; k++) begin
      if (p == 7) d = -1;
      if (p == 0) d = 1;
      p = p + d;
      exp2_pos_q.push_back(p);
    end
    en2 = 1'b1;
    run(40);
    en2 = 1'b0;
    run(2);

    check("pending_steps", exp_pos_q.size(), 0);
    check("loop_pending_steps", exp2_pos_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
